// File: rtl/mux_bus_arbiter8_pkg.sv
// Shared types and sizes for the 8-way round-robin mux arbiter.
// Arbiter FSM states are exported so checkers can bind to them.
package mux_bus_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux_bus_arbiter8_rr_pick8.sv
// Combinational round-robin picker: first set request at or above start, modulo 8.
// The request vector is rotated, priority-encoded from bit 0, then un-rotated.
module rr_pick8
  import mux_bus_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  always_comb begin
    dbl = {req, req};
    rot = dbl[start +: N_REQ];
    any = |req;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    // 3-bit add wraps naturally, which undoes the rotation modulo 8
    idx = start + off;
  end

endmodule

// File: rtl/mux_bus_arbiter8.sv
// Round-robin arbiter owning the select of a shared 8-to-1 datapath mux.
// Tenure is capped at MAX_HOLD cycles; all outputs are registered.
module mux_bus_arbiter8
  import mux_bus_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] CS,
  output logic             sel_valid,
  output logic             owner_done,
  output arb_state_t       dbg_state
);

  // Handshake: req[i] is a level, held by requester i until it is served;
  // grant/CS/sel_valid update one cycle after the sampled req, never combinationally.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [SEL_W-1:0] cs_nxt, rr_ptr, rr_ptr_nxt, pick_start, pick_idx;
  logic             sel_valid_nxt, owner_done_nxt, pick_any, release_own;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;

  // While owning, the scan starts just past the owner so it only wins again last
  assign pick_start = (state == ST_OWN) ? SEL_W'(CS + SEL_W'(1)) : rr_ptr;

  rr_pick8 u_pick (
    .req   (req),
    .start (pick_start),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    cs_nxt         = CS;
    sel_valid_nxt  = sel_valid;
    owner_done_nxt = 1'b0;
    hold_cnt_nxt   = hold_cnt;
    rr_ptr_nxt     = rr_ptr;
    release_own    = !req[CS] || (hold_cnt == HOLD_LAST);
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt     = ST_OWN;
          grant_nxt     = N_REQ'(1) << pick_idx;
          cs_nxt        = pick_idx;
          sel_valid_nxt = 1'b1;
          hold_cnt_nxt  = '0;
        end
      end
      ST_OWN: begin
        if (release_own) begin
          owner_done_nxt = 1'b1;
          rr_ptr_nxt     = SEL_W'(CS + SEL_W'(1));
          hold_cnt_nxt   = '0;
          if (pick_any) begin
            grant_nxt = N_REQ'(1) << pick_idx;
            cs_nxt    = pick_idx;
          end else begin
            state_nxt     = ST_IDLE;
            grant_nxt     = '0;
            cs_nxt        = '0;
            sel_valid_nxt = 1'b0;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      CS         <= '0;
      sel_valid  <= 1'b0;
      owner_done <= 1'b0;
      hold_cnt   <= '0;
      rr_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      CS         <= cs_nxt;
      sel_valid  <= sel_valid_nxt;
      owner_done <= owner_done_nxt;
      hold_cnt   <= hold_cnt_nxt;
      rr_ptr     <= rr_ptr_nxt;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mux_bus_arbiter8.sv
// Bench for mux_bus_arbiter8: four instances (MAX_HOLD 1/2/4/16) share one req bus,
// each checked every cycle against a tenure-level model, plus literal scenario checks.
module tb_mux_bus_arbiter8;
  import mux_bus_arbiter8_pkg::*;

  localparam int NI = 4;
  localparam int MH [NI] = '{1, 2, 4, 16};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] grant_a [NI];
  logic [2:0] cs_a    [NI];
  logic       sv_a    [NI];
  logic       od_a    [NI];
  arb_state_t st_a    [NI];

  int n_cmp = 0;
  int n_err = 0;

  // model state: owner index (-1 idle), cycles held so far, scan pointer, done pulse
  int owner  [NI];
  int tenure [NI];
  int ptr    [NI];
  bit done   [NI];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int MHV = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    localparam int CWV = (g == 0) ? 1 : (g == 1) ? 1 : (g == 2) ? 2 : 4;
    mux_bus_arbiter8 #(.MAX_HOLD(MHV), .CNT_W(CWV)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .grant      (grant_a[g]),
      .CS         (cs_a[g]),
      .sel_valid  (sv_a[g]),
      .owner_done (od_a[g]),
      .dbg_state  (st_a[g])
    );
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic int scan(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  always begin
    @(posedge clk);
    for (int m = 0; m < NI; m++) begin
      done[m] = 1'b0;
      if (!rst_n) begin
        owner[m] = -1; tenure[m] = 0; ptr[m] = 0;
      end else if (owner[m] < 0) begin
        owner[m] = scan(req, ptr[m]);
        tenure[m] = 1;
      end else if (!req[owner[m]] || tenure[m] == MH[m]) begin
        done[m] = 1'b1;
        ptr[m] = (owner[m] + 1) % 8;
        owner[m] = scan(req, ptr[m]);
        tenure[m] = 1;
      end else begin
        tenure[m]++;
      end
    end
    #1;
    for (int m = 0; m < NI; m++) begin
      check($sformatf("m%0d.grant", m), 32'(grant_a[m]), (owner[m] < 0) ? 0 : (1 << owner[m]));
      check($sformatf("m%0d.cs", m), 32'(cs_a[m]), (owner[m] < 0) ? 0 : owner[m]);
      check($sformatf("m%0d.sel_valid", m), 32'(sv_a[m]), 32'(owner[m] >= 0));
      check($sformatf("m%0d.owner_done", m), 32'(od_a[m]), 32'(done[m]));
      check($sformatf("m%0d.state", m), 32'(st_a[m]), 32'((owner[m] >= 0) ? ST_OWN : ST_IDLE));
    end
  end

  // ---------------- stimulus + literal checks ----------------
  initial begin
    for (int m = 0; m < NI; m++) begin
      owner[m] = -1; tenure[m] = 0; ptr[m] = 0; done[m] = 1'b0;
    end

    // reset holds everything at zero even with all requests up
    req = 8'hFF;
    rst_n = 1'b0;
    step(); step();
    check("rst.grant", 32'(grant_a[3]), 32'h00);
    check("rst.cs", 32'(cs_a[3]), 0);
    check("rst.sel_valid", 32'(sv_a[3]), 0);
    rst_n = 1'b1;
    step();
    check("rst_release.grant", 32'(grant_a[3]), 32'h01);

    // single requester, then drop
    req = 8'h00;
    do_reset();
    req = 8'h20;
    step();
    check("single.grant", 32'(grant_a[3]), 32'h20);
    check("single.cs", 32'(cs_a[3]), 5);
    req = 8'h00;
    step();
    check("single_drop.grant", 32'(grant_a[3]), 32'h00);
    check("single_drop.done", 32'(od_a[3]), 1);

    // fairness with MAX_HOLD=2: 0,0,1,1,...,7,7,0
    do_reset();
    req = 8'hFF;
    for (int i = 0; i <= 16; i++) begin
      step();
      check($sformatf("rr.cs[%0d]", i), 32'(cs_a[1]), (i / 2) % 8);
    end

    // handoff 6 -> 1 without an idle cycle
    req = 8'h00;
    do_reset();
    req = 8'h40;
    step();
    req = 8'h42;
    step();
    check("handoff.hold_cs", 32'(cs_a[3]), 6);
    req = 8'h02;
    step();
    check("handoff.cs", 32'(cs_a[3]), 1);
    check("handoff.sel_valid", 32'(sv_a[3]), 1);
    check("handoff.done", 32'(od_a[3]), 1);

    // timeout self-regrant with MAX_HOLD=4
    req = 8'h00;
    do_reset();
    req = 8'h08;
    for (int k = 1; k <= 13; k++) begin
      step();
      check($sformatf("timeout.cs[%0d]", k), 32'(cs_a[2]), 3);
      check($sformatf("timeout.done[%0d]", k), 32'(od_a[2]), 32'(k > 1 && (k - 1) % 4 == 0));
    end

    // mid-tenure reset clears the pointer back to 0
    req = 8'h00;
    do_reset();
    req = 8'h10;
    step(); step(); step();
    check("midrst.pre_cs", 32'(cs_a[3]), 4);
    rst_n = 1'b0;
    step();
    check("midrst.grant", 32'(grant_a[3]), 0);
    check("midrst.cs", 32'(cs_a[3]), 0);
    check("midrst.sel_valid", 32'(sv_a[3]), 0);
    check("midrst.done", 32'(od_a[3]), 0);
    rst_n = 1'b1;
    req = 8'h24;
    step();
    check("midrst.next_cs", 32'(cs_a[3]), 2);
    check("midrst.next_grant", 32'(grant_a[3]), 32'h04);

    // randomized traffic, occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: req = 8'($urandom_range(0, 255));
          1: req = 8'h01 << $urandom_range(0, 7);
          2: req = 8'h00;
          default: req = 8'hFF;
        endcase
      end
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
